// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
//==============================================================================
// Package     : uart_tx_fifo_pkg
// Description : Shared UART definitions used by the TX and RX paths: framing
//               state encodings, the frame/data bit counts of an 8N1
//               character, and the clocks-per-bit helper.
// Contents    : uart_state_e       - serialiser/deserialiser framing states
//               c_data_bits        - data bits per character (8)
//               c_frame_bits       - total bits per frame (start+8+stop = 10)
//               calc_clks_per_bit  - CLK_FREQ / BAUD_RATE (integer division)
// Revision    : 1.0 - initial release
//==============================================================================
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned c_data_bits  = 8;
    localparam int unsigned c_frame_bits = 10;

    // Truncating division: the bit period is rounded down to whole clocks.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx_serializer
// Description : 8N1 frame serialiser. Takes a byte whenever one is available
//               and the line is free (from IDLE, or on the last clock of a
//               stop bit so frames run back-to-back), and shifts it out LSB
//               first. Each bit lasts CLKS_PER_BIT clocks.
// Ports       : clk          in   system clock
//               rst          in   synchronous reset, active high
//               i_data_avail in   a byte is waiting upstream
//               i_data       in   byte to transmit, taken when o_load = 1
//               o_load       out  byte accepted this cycle (upstream pops)
//               o_tx         out  registered serial line, idle high
//               o_busy       out  a frame is in progress
// Revision    : 1.0 - initial release
//==============================================================================
module uart_tx_serializer
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_data_avail,
    input  logic [7:0] i_data,
    output logic       o_load,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int unsigned c_cnt_width = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(CLKS_PER_BIT - 1);
    localparam logic [2:0] c_last_bit = 3'(c_data_bits - 1);

    uart_state_e              r_state;
    uart_state_e              w_state_next;
    logic [c_cnt_width-1:0]   r_baud_cnt;
    logic [c_cnt_width-1:0]   w_baud_cnt_next;
    logic [2:0]               r_bit_idx;
    logic [2:0]               w_bit_idx_next;
    logic [7:0]               r_shift;
    logic [7:0]               w_shift_next;
    logic                     r_tx;
    logic                     w_tx_next;
    logic                     w_load;
    logic                     w_bit_done;

    assign w_bit_done = (r_baud_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = r_baud_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_load          = 1'b0;
        w_tx_next       = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_baud_cnt_next = '0;
                if (i_data_avail) begin
                    w_load       = 1'b1;
                    w_shift_next = i_data;
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                if (w_bit_done) begin
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = '0;
                    w_state_next    = ST_DATA;
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (w_bit_done) begin
                    w_baud_cnt_next = '0;
                    w_shift_next    = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == c_last_bit) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (w_bit_done) begin
                    w_baud_cnt_next = '0;
                    // Chain straight into the next start bit when more data
                    // is queued, so consecutive frames have no idle gap.
                    if (i_data_avail) begin
                        w_load       = 1'b1;
                        w_shift_next = i_data;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Line level follows the current state one clock later; this keeps
        // every bit exactly CLKS_PER_BIT clocks wide and the output glitch-free.
        case (r_state)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = r_shift[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign o_load = w_load;
    assign o_tx   = r_tx;
    assign o_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
//==============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with a byte FIFO in front. The CPU queues
//               bytes with wr_en; they are sent 8N1, LSB first, back-to-back.
// Ports       : clk         in   system clock, rising edge
//               rst         in   synchronous reset, active high
//               wr_en       in   write strobe, one byte per cycle
//               tx_data     in   byte to queue, sampled when wr_en = 1
//               tx          out  UART TX line, idle high
//               tx_ready    out  FIFO can accept a byte
//               tx_busy     out  FIFO non-empty or a frame in progress
//               fifo_full   out  FIFO holds FIFO_DEPTH bytes
//               fifo_empty  out  FIFO holds no bytes
// Revision    : 1.0 - initial release
//==============================================================================
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       fifo_empty
);

    localparam int unsigned c_clks_per_bit = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned c_ptr_width    = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_width:0] c_full_count = (c_ptr_width + 1)'(FIFO_DEPTH);

    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [c_ptr_width-1:0] r_wr_ptr;
    logic [c_ptr_width-1:0] r_rd_ptr;
    logic [c_ptr_width:0]   r_count;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ser_busy;

    assign fifo_full  = (r_count == c_full_count);
    assign fifo_empty = (r_count == '0);
    assign tx_ready   = ~fifo_full;

    // Acceptance uses the registered full flag, so a write that lands while
    // full is dropped even if the serialiser frees a slot on the same edge.
    assign w_push = wr_en & ~fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_serializer (
        .clk          (clk),
        .rst          (rst),
        .i_data_avail (~fifo_empty),
        .i_data       (r_mem[r_rd_ptr]),
        .o_load       (w_pop),
        .o_tx         (tx),
        .o_busy       (w_ser_busy)
    );

    assign tx_busy = w_ser_busy | ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
//==============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A transaction-level
//               model tracks FIFO occupancy and frame timing; accepted bytes
//               go to a scoreboard with their expected start cycle, and an
//               independent line monitor decodes frames from tx and compares.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD_RATE  = 100000;
    localparam int DEPTH      = 16;
    localparam int CPB        = CLK_FREQ / BAUD_RATE;
    localparam int FRAME_CYC  = c_frame_bits * CPB;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       fifo_full;
    logic       fifo_empty;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .tx_data    (tx_data),
        .tx         (tx),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_fifo[$];
    int         m_left;
    int         m_accepted;
    int         cyc;
    int         gen;
    int         n_cmp;
    int         n_err;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus the model's view of that edge: a byte is
    // accepted when fewer than DEPTH are held, a byte leaves the FIFO when the
    // line is free or on the final clock of the current frame, and the line
    // then stays occupied for one full frame.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        bit push;
        bit pop;
        exp_t e;
        wr_en   = w;
        tx_data = d;
        rst     = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_fifo.delete();
            sb_q.delete();
            m_left = 0;
            gen++;
        end else begin
            push = w && (m_fifo.size() < DEPTH);
            pop  = (m_fifo.size() > 0) && (m_left <= 1);
            if (m_left > 0) m_left--;
            if (pop) begin
                e.data  = m_fifo.pop_front();
                e.start = cyc + 1;
                sb_q.push_back(e);
                m_left  = FRAME_CYC;
            end
            if (push) begin
                m_fifo.push_back(d);
                m_accepted++;
            end
        end
        #1;
        check("flags{ready,busy,full,empty}",
              int'({tx_ready, tx_busy, fifo_full, fifo_empty}),
              int'({m_fifo.size() < DEPTH, (m_left > 0) || (m_fifo.size() > 0),
                    m_fifo.size() == DEPTH, m_fifo.size() == 0}));
        if (r) check("tx_after_reset", int'(tx), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_fifo.size() != 0 || m_left != 0) && n < 5000) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        check("drain_within_budget", int'(n < 5000), 1);
        repeat (20) step(1'b0, 8'h00, 1'b0);
    endtask

    // Line monitor: detects a start bit, samples every bit at its centre.
    int         m_s;
    int         m_g;
    bit         m_have;
    exp_t       m_exp;
    logic       m_start_bit;
    logic       m_stop_bit;
    logic [7:0] m_b;

    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                m_s    = cyc;
                m_g    = gen;
                m_have = (sb_q.size() != 0);
                check("frame_expected", int'(m_have), 1);
                if (m_have) begin
                    m_exp = sb_q.pop_front();
                    check("frame_start_cycle", m_s, m_exp.start);
                end
                repeat (CPB / 2) @(negedge clk);
                m_start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    m_b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                m_stop_bit = tx;
                // A frame cut short by reset is not compared.
                if (m_have && m_g == gen) begin
                    check("start_bit", int'(m_start_bit), 0);
                    check("data_byte", int'(m_b), int'(m_exp.data));
                    check("stop_bit", int'(m_stop_bit), 1);
                end
            end
        end
    end

    initial begin
        int budget;
        int acc0;
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        gen        = 0;
        m_left     = 0;
        m_accepted = 0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        tx_data    = 8'h00;

        // Reset state.
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("reset_tx_idle", int'(tx), 1);

        // Single byte into an idle block.
        step(1'b1, 8'hA5, 1'b0);
        drain();

        // Three consecutive bytes, frames back-to-back.
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        drain();

        // Burst of 17: all accepted because the first pops at cycle 1.
        for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 1'b0);
        check("full_after_17", int'(fifo_full), 1);
        // Further writes while full and mid-frame; continuing through the
        // first stop->start pop exercises the drop-on-pop-edge case.
        for (int i = 0; i < FRAME_CYC + 5; i++) step(1'b1, 8'($urandom), 1'b0);
        drain();

        // Reset part-way through a frame with bytes queued.
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
        repeat (2 + 5 * CPB) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("abort_empty", int'(fifo_empty), 1);
        check("abort_not_busy", int'(tx_busy), 0);
        repeat (3 * FRAME_CYC) step(1'b0, 8'h00, 1'b0);

        // Random traffic: 256 accepted bytes, writes often outpacing the line.
        acc0   = m_accepted;
        budget = 0;
        while ((m_accepted - acc0) < 256 && budget < 60000) begin
            step(($urandom_range(0, 99) < 3), 8'($urandom), 1'b0);
            budget++;
        end
        check("random_accepted", m_accepted - acc0, 256);
        drain();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
